// File: rtl/zone_write_scheduler.sv
// zone_write_scheduler: arbitrates the dimming-algorithm stream (A) and the host path (B)
// onto the single MiniLED zone-write port. Write latency is 1 cycle (handshake N -> light_wr N+1).
// Backpressure: readies are low while a frame commit/hold-off is in progress and when reset is asserted.
//
// Ports:
//   I_clk, I_rst              clock, synchronous active-high reset
//   a_valid/a_ready/a_index/a_gray/a_last     algorithm frame stream
//   b_valid/b_ready/b_index/b_gray/b_commit   host single-zone writes
//   light/light_index/light_wr                registered zone write to the driver
//   light_refresh                             one-cycle frame commit pulse
//   busy                                      high during COMMIT and HOLD
//   err_cnt                                   saturating count of dropped out-of-range beats
module zone_write_scheduler #(
   parameter int ZONES   = 384,
   parameter int GRAY_W  = 16,
   parameter int HOLDOFF = 64
) (
   input  logic              I_clk,
   input  logic              I_rst,
   input  logic              a_valid,
   output logic              a_ready,
   input  logic [8:0]        a_index,
   input  logic [GRAY_W-1:0] a_gray,
   input  logic              a_last,
   input  logic              b_valid,
   output logic              b_ready,
   input  logic [8:0]        b_index,
   input  logic [GRAY_W-1:0] b_gray,
   input  logic              b_commit,
   output logic [GRAY_W-1:0] light,
   output logic [8:0]        light_index,
   output logic              light_wr,
   output logic              light_refresh,
   output logic              busy,
   output logic [7:0]        err_cnt
);

   // +1 keeps the counter at least one bit wide when HOLDOFF is 1.
   localparam int         CNT_W   = $clog2(HOLDOFF + 1);
   localparam logic [9:0] ZONES_L = 10'(ZONES);

   typedef enum logic [1:0] {IDLE, RUN, COMMIT, HOLD} state_t;

   state_t             state_q, state_d;
   logic               rr_q, rr_d;          // 0 = A has priority, 1 = B
   logic [CNT_W-1:0]   cnt_q, cnt_d;

   logic               hs;
   logic               beat_flag;
   logic               beat_in_range;
   logic [8:0]         beat_idx;
   logic [GRAY_W-1:0]  beat_gray;

   logic [GRAY_W-1:0]  light_q;
   logic [8:0]         light_index_q;
   logic               light_wr_q;
   logic [7:0]         err_cnt_q;

   // ---------------- FSM: state register ----------------
   always_ff @(posedge I_clk) begin
      if (I_rst) begin
         state_q <= IDLE;
         rr_q    <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         rr_q    <= rr_d;
         cnt_q   <= cnt_d;
      end
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_d = state_q;
      rr_d    = rr_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE, RUN: begin
            if (hs) begin
               if (beat_flag) begin
                  state_d = COMMIT;
               end else if (a_ready) begin
                  state_d = RUN;
               end
            end
            // Only a contended grant moves the priority pointer.
            if (a_valid && b_valid) begin
               rr_d = ~rr_q;
            end
         end
         COMMIT: begin
            cnt_d   = CNT_W'(HOLDOFF - 1);
            state_d = HOLD;
         end
         HOLD: begin
            if (cnt_q == '0) begin
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      logic grant_ok;
      grant_ok      = !I_rst && ((state_q == IDLE) || (state_q == RUN));
      a_ready       = grant_ok && a_valid && (!b_valid || !rr_q);
      b_ready       = grant_ok && b_valid && (!a_valid ||  rr_q);
      busy          = (state_q == COMMIT) || (state_q == HOLD);
      light_refresh = (state_q == COMMIT);
   end

   // Beat selection: at most one ready is high in any cycle.
   always_comb begin
      hs            = a_ready || b_ready;
      beat_idx      = b_ready ? b_index  : a_index;
      beat_gray     = b_ready ? b_gray   : a_gray;
      beat_flag     = b_ready ? b_commit : a_last;
      beat_in_range = ({1'b0, beat_idx} < ZONES_L);
   end

   // ---------------- write datapath ----------------
   always_ff @(posedge I_clk) begin
      if (I_rst) begin
         light_q       <= '0;
         light_index_q <= '0;
         light_wr_q    <= 1'b0;
         err_cnt_q     <= '0;
      end else begin
         light_wr_q <= hs && beat_in_range;
         if (hs && beat_in_range) begin
            light_q       <= beat_gray;
            light_index_q <= beat_idx;
         end
         // Out-of-range beats are dropped but still counted; the count saturates.
         if (hs && !beat_in_range && (err_cnt_q != 8'hFF)) begin
            err_cnt_q <= err_cnt_q + 8'd1;
         end
      end
   end

   assign light       = light_q;
   assign light_index = light_index_q;
   assign light_wr    = light_wr_q;
   assign err_cnt     = err_cnt_q;

endmodule
